opb_master_bridge: RTL and testbench

OPB bus-master engine: it accepts single read/write commands from fabric logic on a valid/ready interface and executes them as OPB master transfers against the slave registers on the OPB segment. It handles arbitration, slave acknowledge, error, retry and timeout, and returns one response per command. It is the initiator counterpart to the fabric-side register slaves. It lets gateware-resident controllers reach the same software-visible registers and BRAMs.

---
 rtl/opb_master_bridge.sv | 178 +++++++++++++++++
 tb/tb_opb_master_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_master_bridge.sv
// opb_master_bridge: fabric-side valid/ready command port driving single OPB
// master transfers. Handles arbitration, ack/error/retry and timeout, and
// returns one response per command.
module opb_master_bridge #(
   parameter int C_OPB_AWIDTH     = 32,
   parameter int C_OPB_DWIDTH     = 32,
   parameter int C_TIMEOUT_CYCLES = 16,
   parameter int C_MAX_RETRIES    = 4
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_rnw,
   input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
   input  logic [C_OPB_DWIDTH-1:0]   cmd_wdata,
   input  logic [C_OPB_DWIDTH/8-1:0] cmd_be,
   output logic                      rsp_valid,
   output logic [C_OPB_DWIDTH-1:0]   rsp_rdata,
   output logic [1:0]                rsp_status,
   output logic                      M_request,
   input  logic                      OPB_MGrant,
   output logic                      M_select,
   output logic [0:C_OPB_AWIDTH-1]   M_ABus,
   output logic [0:C_OPB_DWIDTH/8-1] M_BE,
   output logic [0:C_OPB_DWIDTH-1]   M_DBus,
   output logic                      M_RNW,
   output logic                      M_seqAddr,
   output logic                      M_busLock,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_xferAck,
   input  logic                      OPB_errAck,
   input  logic                      OPB_retry,
   input  logic                      OPB_toutSup
);

   localparam int BW = C_OPB_DWIDTH / 8;
   localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(C_MAX_RETRIES + 1);

   localparam logic [TW-1:0] TOUT_LIMIT  = TW'(C_TIMEOUT_CYCLES);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(C_MAX_RETRIES);

   localparam logic [1:0] ST_OK    = 2'b00;
   localparam logic [1:0] ST_ERR   = 2'b01;
   localparam logic [1:0] ST_TOUT  = 2'b10;
   localparam logic [1:0] ST_RETRY = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    rnw_q, rnw_d;
   logic [C_OPB_AWIDTH-1:0] addr_q, addr_d;
   logic [C_OPB_DWIDTH-1:0] wdata_q, wdata_d;
   logic [BW-1:0]           be_q, be_d;
   logic [RW-1:0]           retry_cnt_q, retry_cnt_d;
   logic [TW-1:0]           tout_cnt_q, tout_cnt_d;
   logic [C_OPB_DWIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]              status_q, status_d;
   logic [TW-1:0]           tout_inc;
   logic [RW-1:0]           retry_inc;

   // Next-state logic: command latch, transfer outcome and counters.
   always_comb begin
      state_d     = state_q;
      rnw_d       = rnw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      retry_cnt_d = retry_cnt_q;
      tout_cnt_d  = tout_cnt_q;
      rdata_d     = rdata_q;
      status_d    = status_q;
      // The slave may suppress the timeout; the count then simply holds.
      tout_inc    = OPB_toutSup ? tout_cnt_q : tout_cnt_q + TW'(1);
      retry_inc   = retry_cnt_q + RW'(1);

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               rnw_d       = cmd_rnw;
               addr_d      = cmd_addr;
               wdata_d     = cmd_wdata;
               be_d        = cmd_be;
               retry_cnt_d = '0;
               tout_cnt_d  = '0;
               state_d     = S_REQ;
            end
         end
         S_REQ: begin
            if (OPB_MGrant) begin
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (OPB_errAck) begin
               status_d = ST_ERR;
               rdata_d  = '0;
               state_d  = S_RESP;
            end else if (OPB_xferAck) begin
               status_d = ST_OK;
               rdata_d  = rnw_q ? OPB_DBus : '0;
               state_d  = S_RESP;
            end else if (OPB_retry) begin
               retry_cnt_d = retry_inc;
               if (retry_inc == RETRY_LIMIT) begin
                  status_d = ST_RETRY;
                  rdata_d  = '0;
                  state_d  = S_RESP;
               end else begin
                  // Re-arbitrate; each attempt gets a fresh timeout window.
                  tout_cnt_d = '0;
                  state_d    = S_REQ;
               end
            end else begin
               tout_cnt_d = tout_inc;
               if (tout_inc == TOUT_LIMIT) begin
                  status_d = ST_TOUT;
                  rdata_d  = '0;
                  state_d  = S_RESP;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state and response registers with synchronous active-low reset.
   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst) begin
         state_q     <= S_IDLE;
         retry_cnt_q <= '0;
         tout_cnt_q  <= '0;
         rdata_q     <= '0;
         status_q    <= ST_OK;
      end else begin
         state_q     <= state_d;
         retry_cnt_q <= retry_cnt_d;
         tout_cnt_q  <= tout_cnt_d;
         rdata_q     <= rdata_d;
         status_q    <= status_d;
      end
   end

   // Command latch; only observed on the bus while selected, so no reset.
   always_ff @(posedge OPB_Clk) begin
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
   end

   assign cmd_ready  = OPB_Rst && (state_q == S_IDLE);
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_rdata  = rdata_q;
   assign rsp_status = status_q;
   assign M_request  = (state_q == S_REQ);
   assign M_select   = (state_q == S_XFER);

   // OR-bus: every master output is zero unless this master is selected.
   assign M_ABus    = M_select ? addr_q : '0;
   assign M_BE      = M_select ? be_q : '0;
   assign M_DBus    = (M_select && !rnw_q) ? wdata_q : '0;
   assign M_RNW     = M_select & rnw_q;
   assign M_seqAddr = 1'b0;
   assign M_busLock = 1'b0;

endmodule

// File: tb/tb_opb_master_bridge.sv
// Testbench for opb_master_bridge: bench acts as arbiter and slave, and a
// round-by-round outcome model predicts latency, status and read data.
module tb_opb_master_bridge;

   localparam int TOUT = 16;
   localparam int MAXR = 4;
   localparam int LIM  = 600;

   logic        OPB_Clk = 1'b0;
   logic        OPB_Rst;
   logic        cmd_valid, cmd_ready, cmd_rnw;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_be;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic        M_request, OPB_MGrant, M_select, M_RNW, M_seqAddr, M_busLock;
   logic [0:31] M_ABus, M_DBus, OPB_DBus;
   logic [0:3]  M_BE;
   logic        OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup;

   int pass_n = 0;
   int chk_n  = 0;
   int cyc    = 0;

   // Scenario per round: grant delay, response type, XFER cycle of response.
   // Types: 0 none, 1 xferAck, 2 errAck, 3 retry, 4 errAck+xferAck.
   int          gdel [8];
   int          rtype[8];
   int          rat  [8];
   int          sup;
   logic [31:0] rd_data;

   // Observations
   int          o_lat, o_rounds, o_selrounds, o_xfer, o_bus_bad, o_idle_bad, o_rsp_cnt;
   int          o_acc_cyc, o_rsp_cyc;
   logic [1:0]  o_status;
   logic [31:0] o_rdata, o_post_rdata, o_sel_abus, o_sel_dbus;
   logic [3:0]  o_sel_be;
   logic        o_sel_rnw, o_post_ready, o_post_valid;

   // Model outputs
   int          e_lat, e_rounds;
   logic [1:0]  e_status;
   logic [31:0] e_rdata;

   opb_master_bridge #(
      .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
      .C_TIMEOUT_CYCLES(TOUT), .C_MAX_RETRIES(MAXR)
   ) dut (
      .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
      .M_request(M_request), .OPB_MGrant(OPB_MGrant), .M_select(M_select),
      .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus), .M_RNW(M_RNW),
      .M_seqAddr(M_seqAddr), .M_busLock(M_busLock), .OPB_DBus(OPB_DBus),
      .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
      .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup)
   );

   always #5 OPB_Clk = ~OPB_Clk;
   always @(posedge OPB_Clk) cyc <= cyc + 1;

   task automatic quiet();
      OPB_MGrant  = 1'b0;
      OPB_xferAck = 1'b0;
      OPB_errAck  = 1'b0;
      OPB_retry   = 1'b0;
      OPB_toutSup = 1'b0;
      OPB_DBus    = '0;
   endtask

   task automatic scn_default();
      for (int r = 0; r < 8; r++) begin
         gdel[r] = 0; rtype[r] = 1; rat[r] = 1;
      end
      sup = 0;
      rd_data = 32'h0;
   endtask

   // Outcome computed round by round from the protocol rules.
   task automatic model_txn(input logic rnw);
      int  retries, x, t, lim;
      bit  fin;
      retries = 0; fin = 0;
      e_lat = 0; e_rounds = 0; e_status = 2'b00; e_rdata = 32'h0;
      for (int r = 0; r < 8 && !fin; r++) begin
         lim = sup + TOUT;
         t = rtype[r];
         if (t != 0 && rat[r] <= lim) x = rat[r];
         else begin x = lim; t = 0; end
         e_lat += gdel[r] + 1 + x;
         e_rounds = r + 1;
         case (t)
            1: begin e_status = 2'b00; e_rdata = rnw ? rd_data : 32'h0; fin = 1; end
            2, 4: begin e_status = 2'b01; e_rdata = 32'h0; fin = 1; end
            3: begin
               retries++;
               if (retries == MAXR) begin e_status = 2'b11; e_rdata = 32'h0; fin = 1; end
            end
            default: begin e_status = 2'b10; e_rdata = 32'h0; fin = 1; end
         endcase
      end
      e_lat += 1;
   endtask

   // Issues one command and plays arbiter/slave per the scenario tables.
   task automatic run_txn(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
      int   n, round, req_cnt, xc;
      logic prev_req, prev_sel, sel_seen;
      bit   done;
      o_lat = -1; o_selrounds = 0; o_xfer = 0; o_bus_bad = 0; o_idle_bad = 0; o_rsp_cnt = 0;
      o_status = 2'bxx; o_rdata = 'x;
      quiet();
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge OPB_Clk); n++; end
      if (!cmd_ready) begin
         chk_n++;
         $display("FAIL ready_wait: cmd_ready=%b want 1 within 50 cycles", cmd_ready);
         return;
      end
      cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be; cmd_valid = 1'b1;
      o_acc_cyc = cyc;
      @(posedge OPB_Clk);
      round = -1; req_cnt = 0; xc = 0; prev_req = 0; prev_sel = 0; sel_seen = 0; done = 0;
      for (n = 1; n <= LIM && !done; n++) begin
         @(negedge OPB_Clk);
         if (n == 1) begin
            cmd_valid = 1'b0; cmd_rnw = $urandom; cmd_addr = $urandom;
            cmd_wdata = $urandom; cmd_be = $urandom;
         end
         if (M_seqAddr !== 1'b0 || M_busLock !== 1'b0) o_idle_bad++;
         if (M_select) begin
            o_xfer++;
            if (M_ABus !== addr || M_BE !== be || M_RNW !== rnw || M_request !== 1'b0 ||
                M_DBus !== (rnw ? 32'h0 : wdata)) o_bus_bad++;
            if (!sel_seen) begin
               sel_seen = 1; o_sel_abus = M_ABus; o_sel_dbus = M_DBus;
               o_sel_be = M_BE; o_sel_rnw = M_RNW;
            end
         end else if (M_ABus !== 0 || M_BE !== 0 || M_DBus !== 0 || M_RNW !== 1'b0) begin
            o_idle_bad++;
         end
         if (M_request && !prev_req) begin round++; req_cnt = 0; xc = 0; end
         if (M_select && !prev_sel) o_selrounds++;
         prev_req = M_request; prev_sel = M_select;
         if (rsp_valid) begin
            o_rsp_cnt++; o_lat = n; o_status = rsp_status; o_rdata = rsp_rdata;
            o_rsp_cyc = cyc; done = 1;
         end
         OPB_MGrant = 1'b0; OPB_xferAck = 1'b0; OPB_errAck = 1'b0; OPB_retry = 1'b0;
         OPB_toutSup = $urandom; OPB_DBus = $urandom;
         if (M_select && round >= 0 && round < 8) begin
            xc++;
            OPB_toutSup = (xc <= sup);
            if (xc == rat[round]) begin
               case (rtype[round])
                  1: begin OPB_xferAck = 1'b1; OPB_DBus = rd_data; end
                  2: OPB_errAck = 1'b1;
                  3: OPB_retry = 1'b1;
                  4: begin OPB_xferAck = 1'b1; OPB_errAck = 1'b1; OPB_DBus = rd_data; end
                  default: ;
               endcase
            end
         end else begin
            // Acks outside a selected cycle must be ignored by the master.
            OPB_xferAck = $urandom; OPB_errAck = $urandom; OPB_retry = $urandom;
            if (M_request && round >= 0 && round < 8) begin
               OPB_MGrant = (req_cnt == gdel[round]);
               req_cnt++;
            end
         end
      end
      o_rounds = round + 1;
      if (!done) begin
         chk_n++;
         $display("FAIL rsp_wait: no rsp_valid within %0d cycles", LIM);
      end
      @(negedge OPB_Clk);
      o_post_ready = cmd_ready; o_post_valid = rsp_valid; o_post_rdata = rsp_rdata;
      quiet();
   endtask

   task automatic test_reset();
      OPB_Rst = 1'b0; quiet();
      cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h0000_1000; cmd_wdata = 32'h5; cmd_be = 4'hF;
      repeat (3) @(negedge OPB_Clk);
      chk_n++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", cmd_ready); else pass_n++;
      chk_n++; if (rsp_valid !== 1'b0) $display("FAIL reset_rspv: got %b want 0", rsp_valid); else pass_n++;
      chk_n++; if (M_request !== 1'b0 || M_select !== 1'b0)
         $display("FAIL reset_req_sel: got %b%b want 00", M_request, M_select); else pass_n++;
      chk_n++; if (M_ABus !== 0 || M_DBus !== 0 || M_BE !== 0 || M_RNW !== 1'b0)
         $display("FAIL reset_bus: abus %h dbus %h want 0", M_ABus, M_DBus); else pass_n++;
      chk_n++; if (rsp_status !== 2'b00 || rsp_rdata !== 32'h0)
         $display("FAIL reset_rsp: status %b rdata %h want 00/0", rsp_status, rsp_rdata); else pass_n++;
      cmd_valid = 1'b0;
      OPB_Rst = 1'b1;
      @(negedge OPB_Clk);
      chk_n++; if (cmd_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", cmd_ready); else pass_n++;
      chk_n++; if (M_request !== 1'b0) $display("FAIL release_req: got %b want 0", M_request); else pass_n++;
   endtask

   task automatic test_write_basic();
      scn_default();
      run_txn(1'b0, 32'h0108_5100, 32'hDEAD_BEEF, 4'hF);
      model_txn(1'b0);
      chk_n++; if (o_lat !== 3) $display("FAIL wr_latency: got %0d want 3", o_lat); else pass_n++;
      chk_n++; if (o_lat !== e_lat) $display("FAIL wr_model_lat: got %0d want %0d", o_lat, e_lat); else pass_n++;
      chk_n++; if (o_sel_dbus !== 32'hDEAD_BEEF) $display("FAIL wr_dbus: got %h want deadbeef", o_sel_dbus); else pass_n++;
      chk_n++; if (o_sel_rnw !== 1'b0) $display("FAIL wr_rnw: got %b want 0", o_sel_rnw); else pass_n++;
      chk_n++; if (o_sel_abus !== 32'h0108_5100 || o_sel_be !== 4'hF)
         $display("FAIL wr_abus_be: got %h/%h want 01085100/f", o_sel_abus, o_sel_be); else pass_n++;
      chk_n++; if (o_status !== 2'b00 || o_rdata !== 32'h0)
         $display("FAIL wr_rsp: status %b rdata %h want 00/0", o_status, o_rdata); else pass_n++;
      chk_n++; if (o_bus_bad !== 0 || o_idle_bad !== 0)
         $display("FAIL wr_bus: bad %0d idle_bad %0d want 0/0", o_bus_bad, o_idle_bad); else pass_n++;
   endtask

   task automatic test_read_wait();
      scn_default();
      rat[0] = 4; rd_data = 32'h1234_5678;
      run_txn(1'b1, 32'h0108_5104, $urandom, 4'hF);
      model_txn(1'b1);
      chk_n++; if (o_lat !== 6 || o_lat !== e_lat) $display("FAIL rd_latency: got %0d want 6 (model %0d)", o_lat, e_lat); else pass_n++;
      chk_n++; if (o_rdata !== 32'h1234_5678) $display("FAIL rd_data: got %h want 12345678", o_rdata); else pass_n++;
      chk_n++; if (o_status !== 2'b00) $display("FAIL rd_status: got %b want 00", o_status); else pass_n++;
      chk_n++; if (o_bus_bad !== 0) $display("FAIL rd_bus: bad %0d want 0", o_bus_bad); else pass_n++;
   endtask

   task automatic test_timeout();
      scn_default();
      rtype[0] = 0; sup = 0;
      run_txn(1'b1, $urandom, $urandom, 4'hF);
      model_txn(1'b1);
      chk_n++; if (o_xfer !== TOUT) $display("FAIL tout_cycles: got %0d want %0d", o_xfer, TOUT); else pass_n++;
      chk_n++; if (o_status !== 2'b10 || o_rdata !== 32'h0)
         $display("FAIL tout_rsp: status %b rdata %h want 10/0", o_status, o_rdata); else pass_n++;
      chk_n++; if (o_lat !== e_lat) $display("FAIL tout_lat: got %0d want %0d", o_lat, e_lat); else pass_n++;
      scn_default();
      sup = 40; rat[0] = 41; rd_data = 32'hA5A5_0F0F;
      run_txn(1'b1, $urandom, $urandom, 4'h3);
      model_txn(1'b1);
      chk_n++; if (o_status !== 2'b00 || o_rdata !== 32'hA5A5_0F0F)
         $display("FAIL toutsup_rsp: status %b rdata %h want 00/a5a50f0f", o_status, o_rdata); else pass_n++;
      chk_n++; if (o_xfer !== 41 || o_lat !== e_lat)
         $display("FAIL toutsup_lat: xfer %0d lat %0d want 41/%0d", o_xfer, o_lat, e_lat); else pass_n++;
   endtask

   task automatic test_retry();
      scn_default();
      for (int r = 0; r < 8; r++) begin
         rtype[r] = 3; rat[r] = $urandom_range(1, 3); gdel[r] = $urandom_range(0, 2);
      end
      run_txn(1'b0, $urandom, $urandom, 4'hF);
      model_txn(1'b0);
      chk_n++; if (o_status !== 2'b11) $display("FAIL retry_status: got %b want 11", o_status); else pass_n++;
      chk_n++; if (o_rounds !== MAXR || o_selrounds !== MAXR)
         $display("FAIL retry_rounds: req %0d sel %0d want %0d", o_rounds, o_selrounds, MAXR); else pass_n++;
      chk_n++; if (o_lat !== e_lat) $display("FAIL retry_lat: got %0d want %0d", o_lat, e_lat); else pass_n++;
      scn_default();
      for (int r = 0; r < 3; r++) begin rtype[r] = 3; rat[r] = $urandom_range(1, 4); end
      rtype[3] = 1; rat[3] = 2; rd_data = 32'hC0DE_0004;
      run_txn(1'b1, $urandom, $urandom, 4'hF);
      model_txn(1'b1);
      chk_n++; if (o_status !== 2'b00 || o_rdata !== 32'hC0DE_0004)
         $display("FAIL retry_ok: status %b rdata %h want 00/c0de0004", o_status, o_rdata); else pass_n++;
      chk_n++; if (o_rounds !== 4 || o_lat !== e_lat)
         $display("FAIL retry_ok_lat: rounds %0d lat %0d want 4/%0d", o_rounds, o_lat, e_lat); else pass_n++;
   endtask

   task automatic test_err_ack();
      scn_default();
      rtype[0] = 4; rat[0] = 2; rd_data = 32'hFFFF_FFFF;
      run_txn(1'b1, $urandom, $urandom, 4'hF);
      chk_n++; if (o_status !== 2'b01) $display("FAIL errack_status: got %b want 01", o_status); else pass_n++;
      chk_n++; if (o_rdata !== 32'h0) $display("FAIL errack_rdata: got %h want 0", o_rdata); else pass_n++;
   endtask

   task automatic test_back_to_back();
      int first_rsp;
      scn_default(); rd_data = 32'h0BAD_F00D;
      run_txn(1'b1, $urandom, $urandom, 4'hF);
      first_rsp = o_rsp_cyc;
      chk_n++; if (o_post_ready !== 1'b1 || o_post_valid !== 1'b0)
         $display("FAIL b2b_post: ready %b valid %b want 1/0", o_post_ready, o_post_valid); else pass_n++;
      scn_default(); gdel[0] = 1;
      run_txn(1'b0, $urandom, $urandom, 4'hC);
      model_txn(1'b0);
      chk_n++; if (o_acc_cyc !== first_rsp + 1)
         $display("FAIL b2b_accept: cycle %0d want %0d", o_acc_cyc, first_rsp + 1); else pass_n++;
      chk_n++; if (o_status !== 2'b00 || o_lat !== e_lat)
         $display("FAIL b2b_second: status %b lat %0d want 00/%0d", o_status, o_lat, e_lat); else pass_n++;
   endtask

   task automatic test_reset_mid();
      int n;
      quiet();
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge OPB_Clk); n++; end
      cmd_rnw = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_be = 4'hF; cmd_valid = 1'b1;
      OPB_MGrant = 1'b1;
      @(negedge OPB_Clk);
      cmd_valid = 1'b0;
      chk_n++; if (M_request !== 1'b1) $display("FAIL rstmid_req: got %b want 1", M_request); else pass_n++;
      @(negedge OPB_Clk);
      chk_n++; if (M_select !== 1'b1) $display("FAIL rstmid_sel: got %b want 1", M_select); else pass_n++;
      OPB_Rst = 1'b0;
      @(negedge OPB_Clk);
      chk_n++; if (M_select !== 1'b0 || M_request !== 1'b0 || M_ABus !== 0 || M_DBus !== 0 ||
                   M_BE !== 0 || M_RNW !== 1'b0)
         $display("FAIL rstmid_bus: sel %b req %b abus %h dbus %h want all 0", M_select, M_request, M_ABus, M_DBus);
      else pass_n++;
      chk_n++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
         $display("FAIL rstmid_ctl: rspv %b ready %b want 0/0", rsp_valid, cmd_ready); else pass_n++;
      @(negedge OPB_Clk);
      chk_n++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
         $display("FAIL rstmid_hold: rspv %b ready %b want 0/0", rsp_valid, cmd_ready); else pass_n++;
      OPB_Rst = 1'b1;
      @(negedge OPB_Clk);
      chk_n++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || M_request !== 1'b0)
         $display("FAIL rstmid_release: ready %b rspv %b req %b want 1/0/0", cmd_ready, rsp_valid, M_request);
      else pass_n++;
      OPB_MGrant = 1'b0;
   endtask

   task automatic test_random();
      int   v;
      logic rnw;
      for (int i = 0; i < 40; i++) begin
         for (int r = 0; r < 8; r++) begin
            gdel[r] = $urandom_range(0, 3);
            rat[r]  = $urandom_range(1, 6);
            v = $urandom_range(0, 9);
            rtype[r] = (v < 5) ? 1 : (v == 5) ? 2 : (v == 6) ? 4 : (v < 9) ? 3 : 0;
         end
         sup = $urandom_range(0, 4);
         rd_data = $urandom;
         rnw = $urandom;
         run_txn(rnw, $urandom, $urandom, 4'($urandom));
         model_txn(rnw);
         chk_n++; if (o_lat !== e_lat) $display("FAIL rnd%0d_lat: got %0d want %0d", i, o_lat, e_lat); else pass_n++;
         chk_n++; if (o_status !== e_status) $display("FAIL rnd%0d_status: got %b want %b", i, o_status, e_status); else pass_n++;
         chk_n++; if (o_rdata !== e_rdata) $display("FAIL rnd%0d_rdata: got %h want %h", i, o_rdata, e_rdata); else pass_n++;
         chk_n++; if (o_rounds !== e_rounds || o_selrounds !== e_rounds)
            $display("FAIL rnd%0d_rounds: req %0d sel %0d want %0d", i, o_rounds, o_selrounds, e_rounds); else pass_n++;
         chk_n++; if (o_bus_bad !== 0 || o_idle_bad !== 0)
            $display("FAIL rnd%0d_bus: bad %0d idle_bad %0d want 0/0", i, o_bus_bad, o_idle_bad); else pass_n++;
         chk_n++; if (o_rsp_cnt !== 1 || o_post_valid !== 1'b0 || o_post_ready !== 1'b1)
            $display("FAIL rnd%0d_rsp: cnt %0d post_valid %b post_ready %b want 1/0/1", i, o_rsp_cnt, o_post_valid, o_post_ready);
         else pass_n++;
         chk_n++; if (o_post_rdata !== e_rdata) $display("FAIL rnd%0d_hold: got %h want %h", i, o_post_rdata, e_rdata); else pass_n++;
      end
   endtask

   initial begin
      OPB_Rst = 1'b0;
      cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
      quiet();
      scn_default();
      test_reset();
      test_write_basic();
      test_read_wait();
      test_timeout();
      test_retry();
      test_err_ack();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_n, chk_n);
      $finish;
   end

endmodule
